subleq_ifetch: RTL

Instruction fetch sequencer for the SUBLEQ core. It reads the three byte-wide operand fields A, B and C of one instruction from program memory at PC, PC+1 and PC+2, assembles them into a 24-bit word, and presents it to the 24-bit instruction register with a one-cycle load-enable pulse. It owns the program counter: it advances it by 3 after each fetch and accepts branch targets from the execute stage. It is the producer side of the instruction-register load interface (`instr_in`/`EN`).

---
 rtl/subleq_ifetch_if.sv | 26 ++
 rtl/subleq_ifetch.sv | 86 ++++++++
 2 files changed

// File: rtl/subleq_ifetch_if.sv
// Fetch-unit bus bundle: control from execute, program-memory read port and IR load port.
interface subleq_ifetch_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              fetch_go;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_next;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_rdata;
  logic [23:0]       instr_out;
  logic              ir_en;
  logic              busy;
  logic [ADDR_W-1:0] pc;

  modport master (
    input  fetch_go, pc_load, pc_next, mem_ack, mem_rdata,
    output mem_req, mem_addr, instr_out, ir_en, busy, pc
  );

  modport slave (
    output fetch_go, pc_load, pc_next, mem_ack, mem_rdata,
    input  mem_req, mem_addr, instr_out, ir_en, busy, pc
  );
endinterface

// File: rtl/subleq_ifetch.sv
// SUBLEQ instruction fetch: reads A,B,C bytes at PC..PC+2, loads the IR with a one-cycle
// pulse and advances PC by 3; accepts branch targets while idle.
module subleq_ifetch #(
  parameter int unsigned      ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic              CLK,
  input logic              RST,
  subleq_ifetch_if.master  bus_io
);

  typedef enum logic [2:0] {StIdle, StF0, StF1, StF2, StLoad} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       hold_q, hold_d;
  logic [23:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] addr_off;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      hold_q  <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      instr_q <= instr_d;
    end
  end

  // Third byte goes straight into instr_out, so only A and B need holding.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    instr_d = instr_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.pc_load)  pc_d    = bus_io.pc_next;
        if (bus_io.fetch_go) state_d = StF0;
      end
      StF0: begin
        if (bus_io.mem_ack) begin
          hold_d[15:8] = bus_io.mem_rdata;
          state_d      = StF1;
        end
      end
      StF1: begin
        if (bus_io.mem_ack) begin
          hold_d[7:0] = bus_io.mem_rdata;
          state_d     = StF2;
        end
      end
      StF2: begin
        if (bus_io.mem_ack) begin
          instr_d = {hold_q, bus_io.mem_rdata};
          pc_d    = pc_q + ADDR_W'(3);
          state_d = StLoad;
        end
      end
      StLoad:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs depend on registered state and PC only.
  always_comb begin
    addr_off = '0;
    unique case (state_q)
      StF1:    addr_off = ADDR_W'(1);
      StF2:    addr_off = ADDR_W'(2);
      default: addr_off = '0;
    endcase
  end

  assign bus_io.mem_req   = (state_q == StF0) || (state_q == StF1) || (state_q == StF2);
  assign bus_io.mem_addr  = pc_q + addr_off;
  assign bus_io.ir_en     = (state_q == StLoad);
  assign bus_io.busy      = (state_q != StIdle);
  assign bus_io.pc        = pc_q;
  assign bus_io.instr_out = instr_q;

endmodule
